inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch unit for the mini RV32 core: owns the program counter, issues word fetches to instruction memory, and presents one instruction at a time to the instruction decoder with a valid/ready handshake. It is the producer side of the `inst` bus the decoder consumes. It also accepts branch redirects from execute and guarantees that no stale instruction reaches the decoder after a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `imem_req` out 1: registered fetch request pulse, one cycle per request.
- `imem_addr` out 32: word address of the request; valid while `imem_req`=1.
- `imem_rvalid` in 1: response strobe, arriving at earliest one cycle after `imem_req`.
- `imem_rdata` in 32: instruction word; valid with `imem_rvalid`.
- `inst` out 32: instruction to the decoder.
- `inst_pc` out 32: PC of `inst`.
- `inst_valid` out 1: `inst`/`inst_pc` hold a live instruction.
- `inst_ready` in 1: decoder consumes `inst` this cycle.
- `redirect_valid` in 1: branch taken; refetch from `redirect_pc`.
- `redirect_pc` in 32: redirect target.
- `fetch_err` out 1: misaligned redirect target seen (see Configuration).

## Operation
- One request outstanding at most; states REQ, WAIT, DROP, HOLD (+ ERR when configured).
- Reset: state REQ, pc=RESET_PC, `imem_req`=0, `imem_addr`=RESET_PC, `inst`=32'h0000_0013 (NOP), `inst_pc`=RESET_PC, `inst_valid`=0, `fetch_err`=0.
- REQ: `imem_req`=1, `imem_addr`=pc for exactly this cycle. Next state WAIT; on redirect, next state DROP with pc<=redirect_pc.
- WAIT: on `imem_rvalid`, `inst`<=rdata, `inst_pc`<=pc, `inst_valid`<=1, pc<=pc+4, go to HOLD. On redirect with `imem_rvalid`, discard data, pc<=redirect_pc, go to REQ. On redirect without `imem_rvalid`, pc<=redirect_pc, go to DROP.
- DROP: wait for the in-flight response. On `imem_rvalid`, discard it and go to REQ. A further redirect in DROP overwrites pc (newest target wins).
- HOLD: `inst_valid`=1 and `inst`/`inst_pc` stable. On `inst_ready`, `inst_valid`<=0 and go to REQ. Redirect has priority over ready: `inst_valid`<=0, pc<=redirect_pc, go to REQ.
- `imem_rvalid` outside WAIT/DROP is ignored.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC becomes 32'h0000_0000.
- `inst` keeps its last value when `inst_valid`=0.
- `rst` asserted in any state overrides everything in that cycle. A response that arrives after reset is ignored because the state is REQ.

## Timing
- Fetch latency: request in cycle N, response at N+k (k≥1), `inst_valid` high at N+k+1.
- Best-case throughput is one instruction per 3 cycles (REQ, WAIT, HOLD with `inst_ready` already high).
- Redirect accepted in cycle N: the next request carries the target address no later than the first REQ after any pending response drains.
- Nothing fetched before the redirect is ever presented with `inst_valid`=1 after it.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 sets `fetch_err`, which stays set until reset.
  - The unit enters ERR and stays there until reset: no further `imem_req`, `inst_valid`=0.
  - Any in-flight response is discarded.
- Undefined:
  - `redirect_pc[1:0]` is forced to 2'b00.
  - `fetch_err` is tied to 0.
  - There is no ERR state.

## Structure
- Shared package `riscv_pkg`:
  - NOP constant 32'h0000_0013.
  - Fetch state enum.
  - XLEN=32 constant.
  - Opcode constants also used by the decoder.
- One sub-module: `ifu_pc_reg`, the PC register with reset/redirect/increment mux. The FSM stays in the top.

## Test plan
- Reset then `imem_rvalid` one cycle after each request, `inst_ready`=1 → requests to 0x0, 0x4, 0x8; `inst_pc` sequence 0x0, 0x4, 0x8; one instruction every 3 cycles.
- `inst_ready`=0 for 5 cycles in HOLD → `inst`/`inst_pc` stable, `inst_valid`=1, no `imem_req`; release → next request to pc+4.
- Redirect to 0x100 while WAIT with response 3 cycles late → stale word is never valid; next request to 0x100 after the response returns.
- Redirect to 0x200 in the same cycle as `imem_rvalid` → data discarded; next cycle `imem_req` to 0x200.
- Redirect to 0x40 in HOLD with `inst_ready`=1 → `inst_valid` drops, consume is not counted, next fetch 0x40; also check that pc 0xFFFF_FFFC is followed by a fetch at 0x0.
- With `IFU_MISALIGN_CHECK_EN`: redirect to 0x102 → `fetch_err`=1 next cycle and no further `imem_req`; `rst` clears it and fetch resumes at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the mini RV32 core: XLEN, NOP, opcodes and fetch states.
// IFU_MISALIGN_CHECK_EN adds the sticky ERR fetch state.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      FS_REQ,
      FS_WAIT,
      FS_DROP,
      FS_HOLD
`ifdef IFU_MISALIGN_CHECK_EN
      , FS_ERR
`endif
   } fetch_state_e;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & {{(XLEN-2){1'b1}}, 2'b00};
   endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Fetch program counter: synchronous reset, redirect load, or +4 increment.
// pc_d_o exposes the next value so the request address can be registered with it.
module ifu_pc_reg
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load_i,
   input  logic [XLEN-1:0] load_pc_i,
   input  logic            inc_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_d_o
);

   logic [XLEN-1:0] pc_q, pc_d;

   // Load beats increment; the +4 wraps naturally at 2^32.
   always_comb begin
      pc_d = pc_q;
      if (load_i)
         pc_d = load_pc_i;
      else if (inc_i)
         pc_d = pc_q + 32'd4;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_d;
   end

   assign pc_o   = pc_q;
   assign pc_d_o = pc_d;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, valid/ready to decode, redirect flush.
// IFU_MISALIGN_CHECK_EN: misaligned redirect targets raise a sticky fetch_err and park in ERR.
module inst_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_err
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, redir_tgt;
   logic            pc_load, pc_inc;
   logic            imem_req_q, imem_req_d;
   logic [XLEN-1:0] imem_addr_q, imem_addr_d;
   logic [XLEN-1:0] inst_q, inst_d, inst_pc_q, inst_pc_d;
   logic            inst_valid_q, inst_valid_d;

`ifdef IFU_MISALIGN_CHECK_EN
   logic fetch_err_q, fetch_err_d, misalign;
   assign misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign redir_tgt = redirect_pc;
   assign fetch_err = fetch_err_q;
`else
   assign redir_tgt = word_align(redirect_pc);
   assign fetch_err = 1'b0;
`endif

   ifu_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
      .clk_i     (clk),
      .rst_i     (rst),
      .load_i    (pc_load),
      .load_pc_i (redir_tgt),
      .inc_i     (pc_inc),
      .pc_o      (pc_q),
      .pc_d_o    (pc_d)
   );

   always_comb begin
      state_d      = state_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
      pc_load      = 1'b0;
      pc_inc       = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      fetch_err_d  = fetch_err_q;
`endif
      case (state_q)
         // REQ is left only once the request pulse is actually on the bus;
         // right after reset the pulse is still being registered.
         FS_REQ: begin
            pc_load = redirect_valid;
            if (imem_req_q)
               state_d = redirect_valid ? FS_DROP : FS_WAIT;
         end
         FS_WAIT: begin
            if (redirect_valid) begin
               pc_load = 1'b1;
               state_d = imem_rvalid ? FS_REQ : FS_DROP;
            end else if (imem_rvalid) begin
               inst_d       = imem_rdata;
               inst_pc_d    = pc_q;
               inst_valid_d = 1'b1;
               pc_inc       = 1'b1;
               state_d      = FS_HOLD;
            end
         end
         FS_DROP: begin
            pc_load = redirect_valid;
            if (imem_rvalid)
               state_d = FS_REQ;
         end
         FS_HOLD: begin
            if (redirect_valid) begin
               pc_load      = 1'b1;
               inst_valid_d = 1'b0;
               state_d      = FS_REQ;
            end else if (inst_ready) begin
               inst_valid_d = 1'b0;
               state_d      = FS_REQ;
            end
         end
`ifdef IFU_MISALIGN_CHECK_EN
         FS_ERR:  state_d = FS_ERR;
`endif
         default: state_d = FS_REQ;
      endcase
`ifdef IFU_MISALIGN_CHECK_EN
      if (misalign) begin
         state_d      = FS_ERR;
         fetch_err_d  = 1'b1;
         inst_valid_d = 1'b0;
         pc_load      = 1'b0;
         pc_inc       = 1'b0;
      end
`endif
      imem_req_d  = (state_d == FS_REQ);
      imem_addr_d = imem_req_d ? pc_d : imem_addr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FS_REQ;
         imem_req_q   <= 1'b0;
         imem_addr_q  <= RESET_PC;
         inst_q       <= NOP_INST;
         inst_pc_q    <= RESET_PC;
         inst_valid_q <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
         fetch_err_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         imem_req_q   <= imem_req_d;
         imem_addr_q  <= imem_addr_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
`ifdef IFU_MISALIGN_CHECK_EN
         fetch_err_q  <= fetch_err_d;
`endif
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = imem_addr_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized scoreboard bench for inst_fetch_unit with a bench-side instruction memory.
// Define IFU_MISALIGN_CHECK_EN to also exercise the sticky fetch_err path.
module tb_inst_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, imem_req, imem_rvalid, inst_valid, inst_ready, redirect_valid, fetch_err;
   logic [31:0] imem_addr, imem_rdata, inst, inst_pc, redirect_pc;

   always #5 clk = ~clk;

   inst_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fetch_err(fetch_err)
   );

   typedef struct { logic [31:0] pc; logic [31:0] data; } item_t;

   int          n_chk = 0, n_fail = 0, cyc = 0, n_cons = 0, last_cons = -1;
   int          lat_mode = 1, mem_cnt = 0;
   bit          mon_en = 0, tput_en = 0, pending = 0, live = 0;
   logic [31:0] exp_addr = RESET_PC, out_addr = '0;
   item_t       exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the next fetch address is the last redirect target (word aligned)
   // or the address after the last delivered word; anything issued before a redirect is dead.
   always @(negedge clk) begin
      cyc++;
      if (mon_en && !rst) begin
         if (imem_req) begin
            chk("req_addr", imem_addr, exp_addr);
            chk("single_outstanding", {31'b0, pending}, 32'd0);
            pending  = 1;
            live     = 1;
            out_addr = exp_addr;
         end
         if (inst_valid) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL stale_inst: got valid pc %h expected no instruction", inst_pc);
            end else begin
               chk("inst", inst, exp_q[0].data);
               chk("inst_pc", inst_pc, exp_q[0].pc);
               if (redirect_valid || inst_ready) begin
                  void'(exp_q.pop_front());
                  if (!redirect_valid) begin
                     n_cons++;
                     if (tput_en && last_cons >= 0) chk("throughput", 32'(cyc - last_cons), 32'd3);
                     last_cons = cyc;
                  end
               end
            end
         end
         if (imem_rvalid && pending) begin
            pending = 0;
            if (live && !redirect_valid) begin
               exp_q.push_back('{out_addr, imem_rdata});
               exp_addr = out_addr + 32'd4;
            end
         end
         if (redirect_valid) begin
            live     = 0;
            exp_addr = redirect_pc & 32'hFFFF_FFFC;
         end
      end
   end

   // Instruction memory: answers each request after lat_mode cycles (0 = random 1..4).
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clk);
         if (imem_req && !rst) mem_cnt = (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
         @(posedge clk); #1;
         imem_rvalid = 1'b0;
         if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = $urandom;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_req(input string name);
      int i;
      for (i = 0; i < 60; i++) begin
         @(negedge clk);
         if (imem_req) break;
      end
      if (i == 60) begin n_chk++; n_fail++; $display("FAIL timeout_req %s: got no imem_req expected one", name); end
   endtask

   task automatic wait_valid(input string name);
      int i;
      for (i = 0; i < 60; i++) begin
         @(negedge clk);
         if (inst_valid) break;
      end
      if (i == 60) begin n_chk++; n_fail++; $display("FAIL timeout_valid %s: got no inst_valid expected one", name); end
   endtask

   task automatic redirect(input logic [31:0] tgt, input logic rdy);
      tick(1);
      redirect_valid = 1'b1; redirect_pc = tgt; inst_ready = rdy;
      tick(1);
      redirect_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      tick(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
      chk("rst_imem_addr", imem_addr, RESET_PC);
      chk("rst_inst", inst, NOP);
      chk("rst_inst_pc", inst_pc, RESET_PC);
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
      mon_en = 1;

      // Back-to-back fetches, 1-cycle memory, decoder always ready.
      tick(1); inst_ready = 1'b1;
      tick(6); last_cons = -1; tput_en = 1;
      tick(15); tput_en = 0;

      // Decoder stall in HOLD.
      inst_ready = 1'b0;
      wait_valid("stall");
      repeat (5) begin
         @(negedge clk);
         chk("stall_valid", {31'b0, inst_valid}, 32'd1);
         chk("stall_no_req", {31'b0, imem_req}, 32'd0);
      end
      tick(1); inst_ready = 1'b1;

      // Redirect in WAIT, response 3 cycles late.
      lat_mode = 3;
      wait_req("late_pre");
      redirect(32'h100, 1'b1);
      wait_req("late_post");
      chk("late_target", imem_addr, 32'h100);

      // Redirect coinciding with the response.
      lat_mode = 1;
      wait_req("same_pre");
      redirect(32'h200, 1'b1);
      @(negedge clk);
      chk("same_req", {31'b0, imem_req}, 32'd1);
      chk("same_target", imem_addr, 32'h200);

      // Redirect in HOLD beats inst_ready.
      inst_ready = 1'b0;
      wait_valid("hold_pre");
      redirect(32'h40, 1'b1);
      @(negedge clk);
      chk("hold_valid_drop", {31'b0, inst_valid}, 32'd0);
      chk("hold_target", imem_addr, 32'h40);

      // PC wrap.
      inst_ready = 1'b0;
      wait_valid("wrap_pre");
      redirect(32'hFFFF_FFFC, 1'b1);
      wait_req("wrap_a");
      chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
      wait_req("wrap_b");
      chk("wrap_zero", imem_addr, 32'h0);

      // Random traffic.
      lat_mode = 0;
      repeat (1500) begin
         tick(1);
         r = $urandom;
         inst_ready     = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 3))
            0:       redirect_pc = 32'hFFFF_FFFC;
            1:       redirect_pc = 32'h100;
            default: redirect_pc = r;
         endcase
`ifdef IFU_MISALIGN_CHECK_EN
         redirect_pc[1:0] = 2'b00;
`endif
      end
      tick(1); redirect_valid = 1'b0; inst_ready = 1'b1;
      tick(30);
      chk("progress", {31'b0, n_cons > 100}, 32'd1);

`ifdef IFU_MISALIGN_CHECK_EN
      inst_ready = 1'b0; lat_mode = 2;
      wait_req("err_pre");
      tick(1);
      mon_en = 0;
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      tick(1); redirect_valid = 1'b0;
      @(negedge clk);
      chk("err_set", {31'b0, fetch_err}, 32'd1);
      repeat (8) begin
         @(negedge clk);
         chk("err_no_req", {31'b0, imem_req}, 32'd0);
         chk("err_no_valid", {31'b0, inst_valid}, 32'd0);
         chk("err_sticky", {31'b0, fetch_err}, 32'd1);
      end
      tick(1); rst = 1'b1; inst_ready = 1'b1; lat_mode = 1;
      tick(2); rst = 1'b0; mem_cnt = 0;
      @(negedge clk);
      chk("err_cleared", {31'b0, fetch_err}, 32'd0);
      exp_q.delete(); pending = 0; live = 0; exp_addr = RESET_PC;
      mon_en = 1;
      wait_req("err_resume");
      chk("err_resume_addr", imem_addr, RESET_PC);
      tick(12);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
